// File: rtl/lock_code_entry_pkg.sv
// Shared definitions for the passcode lock: FSM states, key-count constants
// and the power-on passcode.
package lock_code_entry_pkg;

    typedef enum logic [2:0] {
        ST_LOCKED   = 3'd0,
        ST_ENTRY    = 3'd1,
        ST_CHECK    = 3'd2,
        ST_UNLOCKED = 3'd3,
        ST_ERROR    = 3'd4
    } lock_state_t;

    localparam int KEY_WIDTH           = 4;
    localparam int KEY_CODE_LENGTH     = 4;
    localparam int KEY_DIGIT_BITS      = $clog2(KEY_WIDTH);
    localparam int LOCK_TIMEOUT_CYCLES = 1000;
    localparam int LOCK_ERROR_CYCLES   = 50;

    // First digit sits in the most significant field: 0,1,2,3.
    localparam logic [KEY_CODE_LENGTH*KEY_DIGIT_BITS-1:0] LOCK_DEFAULT_CODE = 8'h1B;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lock_code_entry_if.sv
// Signal bundle between the button monitor / code source and the lock.
interface lock_code_entry_if
    import lock_code_entry_pkg::*;
#(
    parameter int WIDTH       = KEY_WIDTH,
    parameter int CODE_LENGTH = KEY_CODE_LENGTH,
    parameter int DIGIT_BITS  = $clog2(WIDTH)
);
    // keyEdge carries single-cycle press pulses with no back-pressure: any
    // nonzero cycle is one press and is consumed on that edge; codeLoad is a
    // level sampled every edge and acted on only while unlocked.
    logic [WIDTH-1:0]                  keyEdge;
    logic [CODE_LENGTH*DIGIT_BITS-1:0] codeIn;
    logic                              codeLoad;
    logic                              locked;
    logic                              unlocked;
    logic                              error;
    logic [$clog2(CODE_LENGTH+1)-1:0]  digitCount;
    lock_state_t                       state;

    modport master (
        output keyEdge, codeIn, codeLoad,
        input  locked, unlocked, error, digitCount, state
    );

    modport slave (
        input  keyEdge, codeIn, codeLoad,
        output locked, unlocked, error, digitCount, state
    );
endinterface

// File: rtl/lock_code_entry_key_onehot_encoder.sv
// Turns a press vector into a key index; multi-key presses report digit 0
// and raise multi so the entry can be poisoned.
module key_onehot_encoder #(
    parameter int WIDTH      = 4,
    parameter int DIGIT_BITS = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0]      key,
    output logic [DIGIT_BITS-1:0] digit,
    output logic                  multi,
    output logic                  any
);
    logic [DIGIT_BITS-1:0] idx;

    // OR of set-bit indices is exact for one-hot input; multi masks the rest.
    always_comb begin
        idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (key[i]) idx = idx | DIGIT_BITS'(i);
        end
    end

    assign multi = (key & (key - 1'b1)) != '0;
    assign any   = key != '0;
    assign digit = multi ? '0 : idx;
endmodule

// File: rtl/lock_code_entry.sv
// Passcode lock: collects CODE_LENGTH key digits, checks them against a
// reprogrammable stored code and reports locked/unlocked/error.
module lock_code_entry
    import lock_code_entry_pkg::*;
#(
    parameter int WIDTH          = KEY_WIDTH,
    parameter int CODE_LENGTH    = KEY_CODE_LENGTH,
    parameter int DIGIT_BITS     = $clog2(WIDTH),
    parameter logic [CODE_LENGTH*DIGIT_BITS-1:0] DEFAULT_CODE = LOCK_DEFAULT_CODE,
    parameter int TIMEOUT_CYCLES = LOCK_TIMEOUT_CYCLES,
    parameter int ERROR_CYCLES   = LOCK_ERROR_CYCLES
) (
    input logic             clock,
    input logic             reset,
    lock_code_entry_if.slave bus
);
    localparam int CODE_W  = CODE_LENGTH * DIGIT_BITS;
    localparam int CNT_W   = $clog2(CODE_LENGTH + 1);
    localparam int TIMER_W = $clog2(max_int(TIMEOUT_CYCLES, ERROR_CYCLES) + 1);

    lock_state_t         state, state_nxt;
    logic [CODE_W-1:0]   entry_code, entry_nxt;
    logic [CODE_W-1:0]   stored_code, stored_nxt;
    logic [CNT_W-1:0]    count, count_nxt;
    logic                bad, bad_nxt;
    logic [TIMER_W-1:0]  timer, timer_nxt;
    logic                locked_q, unlocked_q, error_q;

    logic [DIGIT_BITS-1:0] digit;
    logic                  multi;
    logic                  press;

    key_onehot_encoder #(.WIDTH(WIDTH), .DIGIT_BITS(DIGIT_BITS)) u_enc (
        .key   (bus.keyEdge),
        .digit (digit),
        .multi (multi),
        .any   (press)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= ST_LOCKED;
            entry_code  <= '0;
            stored_code <= DEFAULT_CODE;
            count       <= '0;
            bad         <= 1'b0;
            timer       <= '0;
            locked_q    <= 1'b1;
            unlocked_q  <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state       <= state_nxt;
            entry_code  <= entry_nxt;
            stored_code <= stored_nxt;
            count       <= count_nxt;
            bad         <= bad_nxt;
            timer       <= timer_nxt;
            // Status flags follow the state register, so they trail it by one edge.
            locked_q    <= (state == ST_LOCKED) || (state == ST_ENTRY) || (state == ST_CHECK);
            unlocked_q  <= (state == ST_UNLOCKED);
            error_q     <= (state == ST_ERROR);
        end
    end

    always_comb begin
        state_nxt  = state;
        entry_nxt  = entry_code;
        stored_nxt = stored_code;
        count_nxt  = count;
        bad_nxt    = bad;
        timer_nxt  = timer;

        unique case (state)
            ST_LOCKED: begin
                if (press) begin
                    state_nxt = ST_ENTRY;
                    entry_nxt = (entry_code << DIGIT_BITS) | CODE_W'(digit);
                    count_nxt = CNT_W'(1);
                    bad_nxt   = multi;
                    timer_nxt = '0;
                end
            end
            ST_ENTRY: begin
                if (press) begin
                    entry_nxt = (entry_code << DIGIT_BITS) | CODE_W'(digit);
                    count_nxt = count + 1'b1;
                    bad_nxt   = bad | multi;
                    timer_nxt = '0;
                    if (count + 1'b1 == CNT_W'(CODE_LENGTH)) state_nxt = ST_CHECK;
                end else if (timer == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
                    state_nxt = ST_LOCKED;
                    entry_nxt = '0;
                    count_nxt = '0;
                    bad_nxt   = 1'b0;
                    timer_nxt = '0;
                end else if (timer != '1) begin
                    timer_nxt = timer + 1'b1;
                end
            end
            ST_CHECK: begin
                state_nxt = (entry_code == stored_code && !bad) ? ST_UNLOCKED : ST_ERROR;
                entry_nxt = '0;
                count_nxt = '0;
                bad_nxt   = 1'b0;
                timer_nxt = '0;
            end
            ST_UNLOCKED: begin
                if (bus.codeLoad) stored_nxt = bus.codeIn;
                if (bus.keyEdge[WIDTH-1]) state_nxt = ST_LOCKED;
            end
            ST_ERROR: begin
                if (timer == TIMER_W'(ERROR_CYCLES - 1)) begin
                    state_nxt = ST_LOCKED;
                    timer_nxt = '0;
                end else if (timer != '1) begin
                    timer_nxt = timer + 1'b1;
                end
            end
            default: state_nxt = ST_LOCKED;
        endcase
    end

    assign bus.locked     = locked_q;
    assign bus.unlocked   = unlocked_q;
    assign bus.error      = error_q;
    assign bus.digitCount = count;
    assign bus.state      = state;
endmodule
